// File: rtl/penc_pkg.sv
// Shared definitions for the registered priority-encoder scheduler:
// index-width helper and mode encodings.
package penc_pkg;

  typedef enum logic {
    MODE_FIXED = 1'b0,
    MODE_RR    = 1'b1
  } penc_mode_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage : penc_pkg

// File: rtl/penc_msb_find.sv
// Combinational highest-set-bit finder: returns {found, index} of the
// most significant 1 in vec (index is 0 when nothing is set).
module penc_msb_find
  import penc_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     vec,
  output logic             found,
  output logic [IDX_W-1:0] index
);

  // Ascending scan so the last hit, i.e. the highest bit, wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec[i]) begin
        found = 1'b1;
        index = IDX_W'(i);
      end
    end
  end

endmodule : penc_msb_find

// File: rtl/penc_rr_scheduler.sv
// Sticky-pending N:1 request scheduler with a valid/ready index output,
// fixed MSB-first or round-robin selection. Optional overrun flag and its
// clear input exist only when PENC_OVERRUN_EN is defined.
module penc_rr_scheduler
  import penc_pkg::*;
#(
  parameter  int unsigned N     = 8,
  localparam int unsigned IDX_W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             mode,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] idx,
  output logic             pend_any
`ifdef PENC_OVERRUN_EN
  ,
  input  logic             clr_ovr,
  output logic             overrun
`endif
);

  logic [N-1:0]     pend_q, pend_d;
  logic             out_valid_q, out_valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [N-1:0]     below_mask;
  logic [N-1:0]     load_mask;
  logic             found_lo, found_all;
  logic [IDX_W-1:0] sel_lo, sel_all, sel;
  logic             load;
  penc_mode_e       mode_e;

  assign mode_e = penc_mode_e'(mode);

  // Round-robin searches strictly below the last served index first.
  always_comb begin
    below_mask = '0;
    for (int unsigned i = 0; i < N; i++) begin
      below_mask[i] = (IDX_W'(i) < rr_ptr_q);
    end
  end

  penc_msb_find #(.N(N)) u_find_lo (
    .vec   (pend_q & below_mask),
    .found (found_lo),
    .index (sel_lo)
  );

  penc_msb_find #(.N(N)) u_find_all (
    .vec   (pend_q),
    .found (found_all),
    .index (sel_all)
  );

  always_comb begin
    sel = sel_all;
    if (mode_e == MODE_RR && found_lo) begin
      sel = sel_lo;
    end
  end

  assign load = found_all && (!out_valid_q || out_ready);

  always_comb begin
    load_mask = '0;
    if (load) begin
      load_mask[sel] = 1'b1;
    end
  end

  always_comb begin
    pend_d      = (pend_q & ~load_mask) | req;
    out_valid_d = out_valid_q;
    idx_d       = idx_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      out_valid_d = 1'b1;
      idx_d       = sel;
      rr_ptr_d    = sel;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q      <= '0;
      out_valid_q <= 1'b0;
      idx_q       <= '0;
      rr_ptr_q    <= '0;
    end else begin
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      idx_q       <= idx_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign idx       = idx_q;
  assign pend_any  = |pend_q;

`ifdef PENC_OVERRUN_EN
  logic overrun_q, overrun_d;

  // A request landing on a bit that is already pending and not being
  // loaded is lost; setting takes priority over a same-cycle clear.
  always_comb begin
    overrun_d = overrun_q & ~clr_ovr;
    if (|(req & pend_q & ~load_mask)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`endif

endmodule : penc_rr_scheduler
